// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: control FSM for a sequential shift-add / radix-2 Booth multiplier.
// Booth mode is present only when MUL_SEQ_BOOTH_EN is defined; otherwise unsigned only.
module mul_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          Run,
   input  logic          Mode,
   input  logic          LSB,
   output logic          Load_ctrl,
   output logic          W_ctrl,
   output logic [5:0]    ADDU_ctrl,
   output logic          SRL_ctrl,
   output logic          Arith_ctrl,
   output logic          Ready,
   output logic [CW-1:0] Count
);
   typedef enum logic [1:0] {IDLE, INIT, CALC, DONE} state_t;
   localparam logic [5:0]    ADDU = 6'b100001;
   localparam logic [5:0]    SUBU = 6'b100011;
   localparam logic [5:0]    NONE = 6'b000000;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state, next;
   logic   start, calc, w, mode_q, q_1;
   assign start = (state == IDLE || state == DONE) && Run;
   assign calc  = state == CALC;
`ifdef MUL_SEQ_BOOTH_EN
   // Mode and Q_1 are captured at the accepting edge so INIT already sees them.
   always_ff @(posedge clk) begin
      if (Reset) begin
         mode_q <= 1'b0;
         q_1    <= 1'b0;
      end else if (start) begin
         mode_q <= Mode;
         q_1    <= 1'b0;
      end else if (calc) begin
         q_1    <= LSB;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = Mode;
   assign mode_q      = 1'b0;
   assign q_1         = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= IDLE;
         Count <= '0;
      end else begin
         state <= next;
         Count <= start ? '0 : calc ? Count + 1'b1 : Count;
      end
   end
   always_comb begin
      next = (state == INIT) ? CALC :
             calc            ? ((Count == LAST) ? DONE : CALC) :
             Run             ? INIT : state;
   end
   always_comb begin
      Load_ctrl  = state == INIT;
      SRL_ctrl   = calc;
      Ready      = state == DONE;
      Arith_ctrl = calc & mode_q;
      w          = calc & (mode_q ? (LSB ^ q_1) : LSB);
      W_ctrl     = w;
      ADDU_ctrl  = !w ? NONE : (mode_q & LSB & !q_1) ? SUBU : ADDU;
   end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: bench for mul_seq_ctrl at WIDTH=8 and WIDTH=32 against an
// operation-position model, plus directed literal checks.
module tb_mul_seq_ctrl;
   localparam logic [5:0] ADDU = 6'b100001;
   localparam logic [5:0] SUBU = 6'b100011;
`ifdef MUL_SEQ_BOOTH_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif
   logic clk = 0, Reset = 0, Run = 0, Mode = 0, LSB = 0;
   logic load8, w8, srl8, ar8, rdy8, load32, w32, srl32, ar32, rdy32;
   logic [5:0] op8, op32, cnt32;
   logic [3:0] cnt8;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   mul_seq_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .Reset(Reset), .Run(Run), .Mode(Mode), .LSB(LSB),
      .Load_ctrl(load8), .W_ctrl(w8), .ADDU_ctrl(op8), .SRL_ctrl(srl8),
      .Arith_ctrl(ar8), .Ready(rdy8), .Count(cnt8));
   mul_seq_ctrl #(.WIDTH(32)) u32 (
      .clk(clk), .Reset(Reset), .Run(Run), .Mode(Mode), .LSB(LSB),
      .Load_ctrl(load32), .W_ctrl(w32), .ADDU_ctrl(op32), .SRL_ctrl(srl32),
      .Arith_ctrl(ar32), .Ready(rdy32), .Count(cnt32));
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   // Model: pos = -1 idle, 0 load cycle, 1..W multiply steps, W+1 product ready.
   int wd[2] = '{8, 32};
   int pos[2] = '{-1, -1};
   bit md[2], prv[2];
   bit armed = 0;
   always @(posedge clk) begin
      if (Reset) armed <= 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (Reset) begin
            pos[k] <= -1;
            md[k]  <= 1'b0;
            prv[k] <= 1'b0;
         end else if (pos[k] < 0 || pos[k] == wd[k] + 1) begin
            if (Run) begin
               pos[k] <= 0;
               md[k]  <= BE && Mode;
               prv[k] <= 1'b0;
            end
         end else begin
            pos[k] <= pos[k] + 1;
            if (pos[k] >= 1) prv[k] <= LSB;
         end
      end
   end
   function automatic logic [5:0] exp_op(bit m, bit lsb, bit pv);
      if (m) return (lsb && !pv) ? SUBU : (!lsb && pv) ? ADDU : 6'd0;
      return lsb ? ADDU : 6'd0;
   endfunction
   function automatic logic [10:0] exp_outs(int p, int w, bit m, bit pv, bit lsb);
      bit c;
      logic [5:0] o;
      c = p >= 1 && p <= w;
      o = c ? exp_op(m, lsb, pv) : 6'd0;
      return {p == 0, o != 6'd0, o, c, c && m, p == w + 1};
   endfunction
   always @(negedge clk) if (armed) begin
      chk("u8_outs", {load8, w8, op8, srl8, ar8, rdy8}, exp_outs(pos[0], 8, md[0], prv[0], LSB));
      chk("u8_count", 64'(cnt8), 64'(pos[0] <= 0 ? 0 : pos[0] - 1));
      chk("u32_outs", {load32, w32, op32, srl32, ar32, rdy32}, exp_outs(pos[1], 32, md[1], prv[1], LSB));
      chk("u32_count", 64'(cnt32), 64'(pos[1] <= 0 ? 0 : pos[1] - 1));
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      Reset = 1;
      Run = 0;
      tick();
      Reset = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int loads, srls, ws, first, n, arc, adds, subs;
      logic [5:0] ops[8];
      logic [5:0] exp36[8];
      logic [7:0] sq;
      int rq[$], lq[$];
      sq = 8'hFD;
      if (BE) exp36 = '{SUBU, ADDU, SUBU, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
      else    exp36 = '{ADDU, 6'd0, ADDU, ADDU, ADDU, ADDU, ADDU, ADDU};
      do_reset();
      #1;
      chk("rst_ready", 64'(rdy32), 0);
      chk("rst_count", 64'(cnt32), 0);
      // WIDTH=32 unsigned, LSB toggling
      Mode = 0; Run = 1; tick(); Run = 0;
      loads = 0; srls = 0; ws = 0; first = 0;
      for (int i = 1; i <= 40; i++) begin
         LSB = i[0];
         #1;
         if (load32) loads++;
         if (srl32) srls++;
         if (w32) ws++;
         if (rdy32 && first == 0) first = i;
         tick();
      end
      chk("r35_loads", 64'(loads), 1);
      chk("r35_srl", 64'(srls), 32);
      chk("r35_w", 64'(ws), 16);
      chk("r35_ready_at", 64'(first), 34);
      // WIDTH=8 Booth, multiplier -3
      do_reset();
      Mode = 1; Run = 1; tick(); Run = 0;
      n = 0; arc = 0;
      for (int i = 1; i <= 10; i++) begin
         LSB = (i >= 2 && i <= 9) ? sq[i-2] : 1'b0;
         #1;
         if (srl8 && n < 8) begin ops[n] = op8; n++; if (ar8) arc++; end
         tick();
      end
      chk("r36_ncalc", 64'(n), 8);
      chk("r36_arith", 64'(arc), BE ? 8 : 0);
      for (int j = 0; j < 8; j++) chk($sformatf("r36_op%0d", j), 64'(ops[j]), 64'(exp36[j]));
      // Run/Mode wiggled during the operation
      do_reset();
      Mode = 1; Run = 1; tick();
      n = 0; loads = 0;
      for (int i = 1; i <= 10; i++) begin
         Run = (i <= 9) ? i[0] : 1'b0;
         Mode = ~i[0];
         LSB = (i >= 2 && i <= 9) ? sq[i-2] : 1'b0;
         #1;
         if (load8) loads++;
         if (srl8 && n < 8) begin ops[n] = op8; n++; end
         if (i == 10) begin
            chk("r39_count", 64'(cnt8), 8);
            chk("r39_ready", 64'(rdy8), 1);
         end
         tick();
      end
      Run = 0; Mode = 0;
      chk("r39_loads", 64'(loads), 1);
      for (int j = 0; j < 8; j++) chk($sformatf("r39_op%0d", j), 64'(ops[j]), 64'(exp36[j]));
      // Reset in the 4th calc cycle
      do_reset();
      Run = 1; tick(); Run = 0; LSB = 1;
      repeat (4) tick();
      Reset = 1; tick(); Reset = 0;
      #1;
      chk("r37_outs", {load8, w8, op8, srl8, ar8, rdy8}, 0);
      chk("r37_count", 64'(cnt8), 0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (rdy8 || w8 || srl8) n++;
         tick();
      end
      chk("r37_quiet", 64'(n), 0);
      // Run held high
      do_reset();
      Run = 1; tick();
      for (int i = 1; i <= 30; i++) begin
         #1;
         if (rdy8) rq.push_back(i);
         if (load8) lq.push_back(i);
         tick();
      end
      Run = 0;
      chk("r38_nready", 64'(rq.size()), 3);
      chk("r38_nload", 64'(lq.size()), 3);
      for (int j = 0; j < 3 && j < rq.size() && j < lq.size(); j++) begin
         chk($sformatf("r38_ready%0d", j), 64'(rq[j]), 64'(10 * j + 10));
         chk($sformatf("r38_load%0d", j), 64'(lq[j]), 64'(10 * j + 1));
      end
      // Mode=1, LSB all ones
      do_reset();
      Mode = 1; LSB = 1; Run = 1; tick(); Run = 0;
      adds = 0; subs = 0; arc = 0;
      for (int i = 1; i <= 10; i++) begin
         #1;
         if (srl8) begin
            if (op8 == ADDU) adds++;
            if (op8 == SUBU) subs++;
            if (ar8) arc++;
         end
         tick();
      end
      chk("r40_addu", 64'(adds), BE ? 0 : 8);
      chk("r40_subu", 64'(subs), BE ? 1 : 0);
      chk("r40_arith", 64'(arc), BE ? 8 : 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
